// File: rtl/ram64_pkg.sv
// Shared constants and helpers for the 64-word RAM built from eight 8-word banks.
package ram64_pkg;

    localparam int unsigned WIDTH_DEFAULT = 16;
    localparam int unsigned N_BANKS       = 8;
    localparam int unsigned N_WORDS       = 8;
    localparam int unsigned BANK_AW       = $clog2(N_BANKS);
    localparam int unsigned WORD_AW       = $clog2(N_WORDS);
    localparam int unsigned ADDR_W        = BANK_AW + WORD_AW;

    // One-hot bank write enable; all zero when load is low.
    function automatic logic [N_BANKS-1:0] bank_decode(
        input logic               load,
        input logic [BANK_AW-1:0] sel
    );
        logic [N_BANKS-1:0] onehot;
        onehot = N_BANKS'(1) << sel;
        return load ? onehot : '0;
    endfunction

endpackage

// File: rtl/ram8.sv
// Eight-entry register-file bank: async-clear storage with a combinational read port.
module ram8
    import ram64_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               load,
    input  logic [WORD_AW-1:0] address,
    input  logic [WIDTH-1:0]   in,
    output logic [WIDTH-1:0]   out
);

    logic [WIDTH-1:0] mem_q [N_WORDS];

    // Words clear while reset is low; a load landing during reset is dropped.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(N_WORDS); i++) begin
                mem_q[i] <= '0;
            end
        end else if (load) begin
            mem_q[address] <= in;
        end
    end

    // Read is asynchronous, so a write cycle still shows the old word until the edge.
    always_comb begin
        out = mem_q[address];
    end

endmodule

// File: rtl/ram64.sv
// 64-word RAM: eight ram8 banks with a load demultiplexer and an output multiplexer.
module ram64
    import ram64_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [WIDTH-1:0]  in,
    input  logic              load,
    input  logic [ADDR_W-1:0] address,
    output logic [WIDTH-1:0]  out
);

    logic [BANK_AW-1:0] bank_sel_c;
    logic [WORD_AW-1:0] word_sel_c;
    logic [N_BANKS-1:0] bank_load_c;
    logic [WIDTH-1:0]   bank_out_c [N_BANKS];

    always_comb begin
        bank_sel_c  = address[ADDR_W-1:WORD_AW];
        word_sel_c  = address[WORD_AW-1:0];
        bank_load_c = bank_decode(load, bank_sel_c);
    end

    for (genvar b = 0; b < int'(N_BANKS); b++) begin : g_bank
        ram8 #(
            .WIDTH(WIDTH)
        ) u_ram8 (
            .clock   (clock),
            .reset_n (reset_n),
            .load    (bank_load_c[b]),
            .address (word_sel_c),
            .in      (in),
            .out     (bank_out_c[b])
        );
    end

    always_comb begin
        out = bank_out_c[bank_sel_c];
    end

endmodule

// File: tb/tb_ram64.sv
// Self-checking bench for ram64: shadow memory model feeding an expected-value queue.
module tb_ram64;

    localparam int unsigned W = 16;

    logic         clock;
    logic         reset_n;
    logic [W-1:0] in;
    logic         load;
    logic [5:0]   address;
    logic [W-1:0] out;

    logic [W-1:0] model [64];
    logic [W-1:0] exp_q [$];
    logic [W-1:0] exp_v;
    int           checks;
    int           errors;

    ram64 #(.WIDTH(W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .in      (in),
        .load    (load),
        .address (address),
        .out     (out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic clear_model();
        for (int i = 0; i < 64; i++) model[i] = '0;
    endtask

    // Present a read address after the falling edge and queue its expected word.
    task automatic drive_read(input int a);
        @(negedge clock);
        load    = 1'b0;
        address = 6'(a);
        exp_q.push_back(model[a]);
        #1;
    endtask

    task automatic do_write(input int a, input logic [W-1:0] d);
        @(negedge clock);
        load    = 1'b1;
        address = 6'(a);
        in      = d;
        @(posedge clock);
        model[a] = d;
        @(negedge clock);
        load = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        load    = 1'b1;
        in      = 16'hDEAD;
        address = 6'd0;
        repeat (3) @(posedge clock);
        clear_model();
        #1;
        checks++;
        if (out !== 16'h0000) begin
            errors++;
            $display("FAIL reset_hold got=%h want=0000", out);
        end
        @(negedge clock);
        load    = 1'b0;
        reset_n = 1'b1;
        for (int a = 0; a < 64; a++) begin
            drive_read(a);
            exp_v = exp_q.pop_front();
            checks++;
            if (out !== exp_v) begin
                errors++;
                $display("FAIL reset_sweep addr=%0d got=%h want=%h", a, out, exp_v);
            end
        end
    endtask

    task automatic test_write_read();
        int addrs [6] = '{5, 45, 4, 6, 13, 37};
        do_write(5, 16'h1234);
        do_write(45, 16'hBEEF);
        foreach (addrs[i]) begin
            drive_read(addrs[i]);
            exp_v = exp_q.pop_front();
            checks++;
            if (out !== exp_v) begin
                errors++;
                $display("FAIL write_read addr=%0d got=%h want=%h", addrs[i], out, exp_v);
            end
        end
    endtask

    task automatic test_read_during_write();
        do_write(9, 16'h00AA);
        @(negedge clock);
        load    = 1'b1;
        in      = 16'h5555;
        address = 6'd9;
        exp_q.push_back(16'h00AA);
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (out !== exp_v) begin
            errors++;
            $display("FAIL rdw_before got=%h want=%h", out, exp_v);
        end
        exp_q.push_back(16'h5555);
        @(posedge clock);
        model[9] = 16'h5555;
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (out !== exp_v) begin
            errors++;
            $display("FAIL rdw_after got=%h want=%h", out, exp_v);
        end
        @(negedge clock);
        load = 1'b0;
    endtask

    task automatic test_load_low();
        in = 16'hFFFF;
        for (int a = 0; a < 64; a++) begin
            drive_read(a);
            exp_v = exp_q.pop_front();
            checks++;
            if (out !== exp_v) begin
                errors++;
                $display("FAIL load_low addr=%0d got=%h want=%h", a, out, exp_v);
            end
        end
    endtask

    task automatic test_bank_boundary();
        int addrs [4] = '{7, 8, 15, 0};
        do_write(7, 16'h0007);
        do_write(8, 16'h0008);
        foreach (addrs[i]) begin
            drive_read(addrs[i]);
            exp_v = exp_q.pop_front();
            checks++;
            if (out !== exp_v) begin
                errors++;
                $display("FAIL bank_boundary addr=%0d got=%h want=%h", addrs[i], out, exp_v);
            end
        end
    endtask

    // Load held high while address and data change every cycle.
    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            int a;
            logic [W-1:0] d;
            a = int'($urandom_range(0, 62));
            d = W'($urandom);
            @(negedge clock);
            load    = 1'b1;
            address = 6'(a);
            in      = d;
            @(posedge clock);
            model[a] = d;
        end
        @(negedge clock);
        load = 1'b0;
        for (int a = 0; a < 64; a++) begin
            drive_read(a);
            exp_v = exp_q.pop_front();
            checks++;
            if (out !== exp_v) begin
                errors++;
                $display("FAIL back_to_back addr=%0d got=%h want=%h", a, out, exp_v);
            end
        end
    endtask

    task automatic test_async_reset();
        do_write(63, 16'h1111);
        do_write(20, 16'h2222);
        @(negedge clock);
        load    = 1'b1;
        in      = 16'h7777;
        address = 6'd63;
        #2;
        reset_n = 1'b0;
        clear_model();
        #1;
        checks++;
        if (out !== 16'h0000) begin
            errors++;
            $display("FAIL async_reset_immediate got=%h want=0000", out);
        end
        @(posedge clock);
        @(negedge clock);
        load    = 1'b0;
        reset_n = 1'b1;
        #1;
        checks++;
        if (out !== 16'h0000) begin
            errors++;
            $display("FAIL async_reset_first_cycle got=%h want=0000", out);
        end
        for (int k = 0; k < 3; k++) begin
            drive_read(k == 0 ? 63 : (k == 1 ? 20 : 9));
            exp_v = exp_q.pop_front();
            checks++;
            if (out !== exp_v) begin
                errors++;
                $display("FAIL async_reset_after k=%0d got=%h want=%h", k, out, exp_v);
            end
        end
        do_write(63, 16'hA5A5);
        drive_read(63);
        exp_v = exp_q.pop_front();
        checks++;
        if (out !== exp_v) begin
            errors++;
            $display("FAIL async_reset_resume got=%h want=%h", out, exp_v);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b1;
        load    = 1'b0;
        in      = '0;
        address = '0;
        clear_model();
        test_reset();
        test_write_read();
        test_read_during_write();
        test_load_low();
        test_bank_boundary();
        test_back_to_back();
        test_async_reset();
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
